vgm_apb_tri_slave_regs: RTL
===========================

Name: vgm_apb_tri_slave_regs

Overview:
- Parametrised APB slave register bank for the tri-state APB bus variant, in which a single shared bidirectional PDATA carries both write and read data.
- Generalises the tri-state master-side block: configurable data/address width, register count, base address and wait states; byte strobes; error response; slave-side bus turnaround control.
- Sits on the tri-state APB bus as the reference DUT/responder for master-agent verification and as a small config-register block in designs.

Parameters:
- DATA_WIDTH, 32, PDATA/register width; multiple of 8, range 8..64.
- ADDR_WIDTH, 32, PADDR width.
- NUM_REGS, 8, number of registers, 1..256.
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8.
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion, 0..15.

Ports:
- PCLK  input  1  bus clock; all state updates on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PADDR  input  ADDR_WIDTH  byte address.
- PWRITE  input  1  1 = write, 0 = read.
- PSTRB  input  DATA_WIDTH/8  write byte-lane enables.
- PDATA  inout  DATA_WIDTH  shared data bus; driven by this block only as specified below, otherwise Z.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response, valid only while PREADY=1.

Behaviour:
- Reset: all registers 0, wait counter 0, FSM IDLE, PREADY=0, PSLVERR=0, PDATA=Z. Assertion of PRESETn takes effect immediately (async), including PDATA release mid-transfer; any in-flight write is discarded.
- FSM: IDLE -> SETUP when PSEL=1 & PENABLE=0. SETUP -> ACCESS on the next edge; wait counter loads WAIT_STATES. ACCESS -> IDLE, or -> SETUP for back-to-back transfers, on the edge where PREADY=1. While in ACCESS with counter ≠ 0, the counter decrements each cycle.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (counter==0). Combinational from registered state. 0 in all other states.
- Completion latency: exactly WAIT_STATES+1 access-phase cycles.
- Decode: offset = PADDR − BASE_ADDR, computed in ADDR_WIDTH bits with wrap.
  - valid = offset < NUM_REGS·(DATA_WIDTH/8) and offset aligned to DATA_WIDTH/8.
  - index = offset / (DATA_WIDTH/8).
  - Address is captured at SETUP; PADDR changes during ACCESS are ignored.
- PSLVERR = PREADY & !valid.
- Write: commits on the rising edge that ends the PREADY=1 cycle, only if valid. Byte lane k is updated from PDATA[8k+7:8k] only where PSTRB[k]=1. PDATA is sampled in that completion cycle. An invalid write leaves all registers unchanged.
- Read: PDATA driven only when state==ACCESS & PSEL & PENABLE & !PWRITE, i.e. every access-phase cycle including wait cycles. Value is reg[index] if valid, else all zeros. Z in SETUP, IDLE, all write cycles, and the cycle after completion. This guarantees a one-cycle turnaround against master-driven writes.
- PSTRB is ignored on reads.
- Protocol violations:
  - PENABLE=1 seen in IDLE (no setup phase): ignored, no PREADY, no drive.
  - PSEL dropping during ACCESS: return to IDLE, no commit, PDATA=Z next cycle.
- Back-to-back: a write completion followed immediately by a read SETUP to the same index returns the new value in the read access phase.

Test Plan:
- Reset then read all NUM_REGS=8 addresses 0x00..0x1C, WAIT_STATES=0 -> each read completes in 1 access cycle, PDATA=0, PSLVERR=0; PDATA=Z in every setup cycle.
- Write 0xDEADBEEF to 0x08 with PSTRB=4'b1111, then write 0x00000011 to 0x08 with PSTRB=4'b0001, then read 0x08 -> 0xDEADBE11.
- WAIT_STATES=3: read of 0x04 -> PREADY low for 3 access cycles and high on the 4th; PDATA driven in all 4 cycles.
- Access 0x20 (out of range) and 0x06 (misaligned): a write of 0xFFFFFFFF followed by readback of all registers -> PSLVERR=1 on both completions, read data 0, no register changed.
- Assert PRESETn low during the 2nd wait cycle of a read -> PDATA=Z and PREADY=0 immediately; after release, all registers read 0.
- Back-to-back write 0x12345678 to 0x0C and read 0x0C with no idle cycle -> read returns 0x12345678; PDATA undriven by the slave during the write.

Source files
------------

// File: rtl/vgm_apb_tri_slave_regs.sv
// rtl/vgm_apb_tri_slave_regs.sv - APB register bank slave for the tri-state (shared PDATA) bus variant
//
// Purpose:
//   NUM_REGS x DATA_WIDTH register bank on an APB bus whose read and write data
//   share one bidirectional PDATA. Supports byte strobes, programmable wait
//   states, an error response for out-of-range or misaligned addresses, and
//   releases PDATA so that a master-driven write never overlaps a slave drive.
//
// Ports:
//   PCLK     in     bus clock, rising-edge active
//   PRESETn  in     asynchronous active-low reset
//   PSEL     in     slave select
//   PENABLE  in     access-phase indicator
//   PADDR    in     byte address [ADDR_WIDTH]
//   PWRITE   in     1 = write, 0 = read
//   PSTRB    in     write byte-lane enables [DATA_WIDTH/8]
//   PDATA    inout  shared data bus [DATA_WIDTH]; driven only during read access cycles
//   PREADY   out    transfer completion
//   PSLVERR  out    error response, qualified by PREADY
module vgm_apb_tri_slave_regs #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic                      PWRITE,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    inout  wire  [DATA_WIDTH-1:0]     PDATA,
    output logic                      PREADY,
    output logic                      PSLVERR
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SPAN = NUM_REGS * NB;

    // The bus setup cycle is recognised while idle, so the edge that ends it
    // moves straight into ACCESS; this keeps completion at WAIT_STATES+1
    // access-phase cycles.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_valid;
    logic [IW-1:0]         r_index;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_valid;
    logic [IW-1:0]         w_index;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_drive;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Offset wraps in ADDR_WIDTH bits, so addresses below BASE_ADDR land far
    // above the register span and decode as invalid.
    assign w_offset = PADDR - BASE_ADDR;
    assign w_valid  = (w_offset < ADDR_WIDTH'(SPAN)) &&
                      ((w_offset % ADDR_WIDTH'(NB)) == '0);
    assign w_index  = IW'(w_offset / ADDR_WIDTH'(NB));

    assign w_setup  = PSEL && !PENABLE;
    assign w_access = (r_state == ST_ACCESS) && PSEL && PENABLE;

    assign PREADY   = w_access && (r_cnt == 4'd0);
    assign PSLVERR  = PREADY && !r_valid;

    // Read data is driven through every access cycle including wait cycles;
    // it drops the moment the state leaves ACCESS, which gives the master a
    // free turnaround cycle after each completion.
    assign w_drive  = w_access && !PWRITE;
    assign w_rdata  = r_valid ? r_regs[r_index] : '0;
    assign PDATA    = w_drive ? w_rdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_valid <= 1'b0;
            r_index <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // PENABLE without a preceding setup phase is ignored here.
                    if (w_setup) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_valid <= w_valid;
                        r_index <= w_index;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer: no commit.
                        r_state <= ST_IDLE;
                    end else if (!PENABLE) begin
                        // A fresh setup phase restarts the transfer.
                        r_cnt   <= 4'(WAIT_STATES);
                        r_valid <= w_valid;
                        r_index <= w_index;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (PREADY && PWRITE && r_valid) begin
                for (int k = 0; k < NB; k++) begin
                    if (PSTRB[k]) begin
                        r_regs[r_index][8*k +: 8] <= PDATA[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule
